// File: rtl/router_pkg.sv
// Shared types and constants for the 8x8 serial router.
// Imported by the per-output arbiter and the round-robin picker.
package router_pkg;

  localparam int N_PORTS      = 8;
  localparam int ADDR_BITS    = 4;
  localparam int PAD_CYCLES   = 10;
  localparam int PAYLOAD_BITS = 32;
  localparam int PKT_CYCLES   = ADDR_BITS + PAD_CYCLES + PAYLOAD_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef logic [$clog2(N_PORTS)-1:0] port_idx_t;

  // Port after p, wrapping from the last port back to port 0.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(N_PORTS - 1)) ? '0 : port_idx_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Request/grant bundle between the header decoders and one output arbiter.
// master = requesting side, slave = arbiter side.
interface router_out_arbiter_if
  import router_pkg::*;
#(
  parameter int CNT_W = 7
);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] grant;
  logic               grant_vld;
  port_idx_t          grant_idx;
  logic               timeout_err;
  logic [CNT_W-1:0]   busy_cnt;

  modport master (
    output req,
    input  grant, grant_vld, grant_idx, timeout_err, busy_cnt
  );

  modport slave (
    input  req,
    output grant, grant_vld, grant_idx, timeout_err, busy_cnt
  );

endinterface

// File: rtl/router_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping around. Rotate, priority-encode the lowest bit, rotate back.
module rr_pick
  import router_pkg::*;
#(
  parameter int N  = N_PORTS,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  always_comb begin
    w_dbl = {req, req} >> rr_ptr;
    w_rot = w_dbl[N-1:0];
    found = |w_rot;
    // Scan downward so the lowest set bit (closest to rr_ptr) wins.
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
    w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
    idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Per-output round-robin arbiter: one grant at a time, held until the owner's
// packet ends, with a hold watchdog that forces release of a stuck owner.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  router_out_arbiter_if.slave bus
);

  arb_state_t         r_state, w_state_nx;
  logic [N_PORTS-1:0] r_grant, w_grant_nx;
  port_idx_t          r_grant_idx, w_grant_idx_nx;
  port_idx_t          r_rr_ptr, w_rr_ptr_nx;
  logic [CNT_W-1:0]   r_busy_cnt, w_busy_cnt_nx;
  logic               r_timeout, w_timeout_nx;

  logic               w_pick_found;
  port_idx_t          w_pick_idx;
  logic               w_owner_req;

  rr_pick #(.N(N_PORTS)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (r_rr_ptr),
    .found  (w_pick_found),
    .idx    (w_pick_idx)
  );

  assign w_owner_req = bus.req[r_grant_idx];

  // NOTE: every signal gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_grant_idx_nx = r_grant_idx;
    w_rr_ptr_nx    = r_rr_ptr;
    w_busy_cnt_nx  = r_busy_cnt;
    w_timeout_nx   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant_nx    = '0;
        w_busy_cnt_nx = '0;
        if (w_pick_found) begin
          w_grant_nx     = {{(N_PORTS-1){1'b0}}, 1'b1} << w_pick_idx;
          w_grant_idx_nx = w_pick_idx;
          w_state_nx     = BUSY;
        end
      end
      BUSY: begin
        if (!w_owner_req) begin
          w_grant_nx    = '0;
          w_busy_cnt_nx = '0;
          w_rr_ptr_nx   = next_port(r_grant_idx);
          w_state_nx    = IDLE;
        end else if (r_busy_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_grant_nx    = '0;
          w_busy_cnt_nx = '0;
          w_timeout_nx  = 1'b1;
          w_rr_ptr_nx   = next_port(r_grant_idx);
          w_state_nx    = DRAIN;
        end else if (r_busy_cnt != CNT_W'(MAX_HOLD)) begin
          w_busy_cnt_nx = r_busy_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // Keep the timed-out owner off the output until its frame really ends.
        w_grant_nx    = '0;
        w_busy_cnt_nx = '0;
        if (!w_owner_req) w_state_nx = IDLE;
      end
      default: begin
        w_grant_nx    = '0;
        w_busy_cnt_nx = '0;
        w_state_nx    = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_busy_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_grant_idx <= w_grant_idx_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_busy_cnt  <= w_busy_cnt_nx;
      r_timeout   <= w_timeout_nx;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_vld   = |r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.timeout_err = r_timeout;
  assign bus.busy_cnt    = r_busy_cnt;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: stimulus pushes expected grant owners
// into a scoreboard, a negedge monitor pops and compares on each new grant.
module tb_router_out_arbiter;
  import router_pkg::*;

  localparam int MAX_HOLD = 64;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);

  logic clock;
  logic reset_n;

  router_out_arbiter_if #(.CNT_W(CNT_W)) bus ();

  router_out_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_timeouts = 0;
  int exp_q[$];
  logic      prev_vld;
  port_idx_t prev_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bus.grant_vld) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: no grant within %0d cycles", name, budget);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_vld <= 1'b0;
      prev_idx <= '0;
    end else begin
      check("onehot0", 32'($onehot0(bus.grant)), 32'd1);
      check("vld_or", 32'(bus.grant_vld), 32'(|bus.grant));
      if (!bus.grant_vld) check("busy_idle_zero", 32'(bus.busy_cnt), 32'd0);
      if (bus.timeout_err) n_timeouts++;
      if (bus.grant_vld && prev_vld) check("no_preempt", 32'(bus.grant_idx), 32'(prev_idx));
      if (bus.grant_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got grant 0x%0h, expected no grant", bus.grant);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("sb_grant", 32'(bus.grant), 32'(1) << e);
          check("sb_idx", 32'(bus.grant_idx), 32'(e));
        end
      end
      prev_vld <= bus.grant_vld;
      prev_idx <= bus.grant_idx;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    tick(2);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_vld", 32'(bus.grant_vld), 32'd0);
    check("rst_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("rst_busy", 32'(bus.busy_cnt), 32'd0);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    bus.req = '0;
    #2;
    do_reset();

    // Single request: 1-cycle latency, held 46 cycles, busy reaches 45.
    exp_q.push_back(0);
    bus.req = 8'h01;
    tick(1);
    check("single_grant", 32'(bus.grant), 32'h01);
    check("single_busy0", 32'(bus.busy_cnt), 32'd0);
    tick(45);
    check("single_busy45", 32'(bus.busy_cnt), 32'd45);
    check("single_held", 32'(bus.grant), 32'h01);
    bus.req = 8'h00;
    tick(1);
    check("single_release", 32'(bus.grant), 32'h00);
    check("single_no_to", 32'(n_timeouts), 32'd0);

    // Round robin from rr_ptr=0 with req=0F: 0,1,2,3,0.
    do_reset();
    bus.req = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(order[k]);
      wait_grant("rr_wait", 4);
      check("rr_owner", 32'(bus.grant_idx), 32'(order[k]));
      tick(45);
      check("rr_busy45", 32'(bus.busy_cnt), 32'd45);
      bus.req = 8'h0F & ~(8'h01 << order[k]);
      tick(1);
      check("rr_idle_gap", 32'(bus.grant), 32'h00);
      bus.req = (k == 4) ? 8'h00 : 8'h0F;
    end
    tick(2);

    // Wrap: serve port 6 so rr_ptr=7, then req=81 goes 7 then 0.
    exp_q.push_back(6);
    bus.req = 8'h40;
    wait_grant("wrap_p6", 4);
    tick(3);
    bus.req = 8'h00;
    tick(1);
    exp_q.push_back(7);
    exp_q.push_back(0);
    bus.req = 8'h81;
    tick(1);
    check("wrap_first", 32'(bus.grant), 32'h80);
    tick(4);
    bus.req = 8'h01;
    tick(1);
    check("wrap_gap", 32'(bus.grant), 32'h00);
    tick(1);
    check("wrap_second", 32'(bus.grant), 32'h01);
    tick(2);
    bus.req = 8'h00;
    tick(2);

    // Timeout: port 2 stuck, forced release after 64 cycles, DRAIN holds port 5 off.
    exp_q.push_back(2);
    bus.req = 8'h04;
    wait_grant("to_wait", 4);
    tick(63);
    check("to_busy63", 32'(bus.busy_cnt), 32'd63);
    check("to_still_held", 32'(bus.grant), 32'h04);
    tick(1);
    check("to_forced_rel", 32'(bus.grant), 32'h00);
    check("to_pulse", 32'(bus.timeout_err), 32'd1);
    bus.req = 8'h24;
    tick(1);
    check("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    check("to_drain", 32'(bus.grant), 32'h00);
    tick(30);
    check("to_drain_long", 32'(bus.grant), 32'h00);
    exp_q.push_back(5);
    bus.req = 8'h20;
    tick(1);
    check("to_drain_exit", 32'(bus.grant), 32'h00);
    tick(1);
    check("to_p5_grant", 32'(bus.grant), 32'h20);
    check("to_count", 32'(n_timeouts), 32'd1);
    bus.req = 8'h00;
    tick(2);

    // Reset mid-grant clears outputs without a clock edge.
    exp_q.push_back(4);
    bus.req = 8'h10;
    wait_grant("mr_wait", 4);
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_grant", 32'(bus.grant), 32'h00);
    check("mr_busy", 32'(bus.busy_cnt), 32'd0);
    check("mr_vld", 32'(bus.grant_vld), 32'd0);
    bus.req = 8'h30;
    tick(2);
    reset_n = 1'b1;
    exp_q.push_back(4);
    tick(1);
    check("mr_regrant", 32'(bus.grant), 32'h10);
    bus.req = 8'h00;
    tick(2);

    // Owner 1 drops while port 3 raises: one idle cycle, then port 3.
    exp_q.push_back(1);
    bus.req = 8'h02;
    wait_grant("sim_wait", 4);
    tick(3);
    exp_q.push_back(3);
    bus.req = 8'h08;
    tick(1);
    check("sim_gap", 32'(bus.grant), 32'h00);
    tick(1);
    check("sim_grant3", 32'(bus.grant), 32'h08);
    bus.req = 8'h00;
    tick(2);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("timeout_total", 32'(n_timeouts), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
Per-output-port round-robin arbiter for the 8x8 serial router. Input-port header decoders raise a request toward this output once the 4-bit destination address is captured. The arbiter grants exactly one input at a time and holds the grant until that input's packet ends. It then rotates priority so concurrent senders to one destination are served fairly. A hold watchdog prevents a stuck input from locking the output. One instance per output port sits between the header decoders and the output mux.

Parameters:
N_PORTS, 8, number of requesting input ports
MAX_HOLD, 64, max cycles a grant may be held before forced release (nominal packet = 46 cycles: 4 header + 10 pad + 32 payload)
CNT_W, $clog2(MAX_HOLD+1), hold counter width

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req  input  N_PORTS  req[i]=1: input i has a packet for this output; held high until its frame ends
grant  output  N_PORTS  one-hot grant, registered; all zero when idle
grant_vld  output  1  1 while any grant bit is set
grant_idx  output  $clog2(N_PORTS)  index of granted input; holds last value when idle
timeout_err  output  1  one-cycle pulse when the watchdog forces a release
busy_cnt  output  CNT_W  cycles the current grant has been held; 0 when idle

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: grant=0, grant_vld=0, grant_idx=0, timeout_err=0, busy_cnt=0, state=IDLE, rr_ptr=0.
- Reset asserted mid-grant clears everything immediately, with no wait for a clock edge.
- State IDLE:
  - If req!=0, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... N_PORTS-1, 0, ...).
  - Grant is registered at the next edge, so latency is 1 cycle from req to grant. Go to BUSY.
- State BUSY:
  - busy_cnt increments each cycle, saturating at MAX_HOLD.
  - Requests from other ports are ignored; no preemption.
  - If req[grant_idx]==0: clear grant at the next edge, set rr_ptr=grant_idx+1 mod N_PORTS, go to IDLE.
  - If req[grant_idx] is still 1 and busy_cnt==MAX_HOLD-1: clear grant, pulse timeout_err for 1 cycle, set rr_ptr=grant_idx+1 mod N_PORTS, go to DRAIN.
- State DRAIN:
  - grant=0. Wait until req[owner]==0, so the same packet cannot be regranted mid-stream. Then go to IDLE.
  - Other requesters wait during DRAIN.
- Release always passes through IDLE, giving at least one cycle with grant=0 between packets. This guarantees frameo_n goes high between packets.
- If the owner drops req and another port raises req in the same cycle, the new request is considered in the IDLE cycle that follows.
- rr_ptr wraps from N_PORTS-1 to 0.
- grant is always one-hot or zero. grant_vld equals the OR of grant.

Decomposition:
- router_pkg holds:
  - N_PORTS=8, ADDR_BITS=4, PAD_CYCLES=10, PAYLOAD_BITS=32, PKT_CYCLES=46.
  - typedef arb_state_t enum {IDLE, BUSY, DRAIN}.
  - typedef port_idx_t logic[$clog2(N_PORTS)-1:0].
- Sub-module rr_pick: combinational rotate / priority-encode / rotate-back. Inputs req and rr_ptr; outputs a found flag and idx. Reused by future input-side schedulers.

Test Plan:
- Single request: after reset, req=8'h01 held for 46 cycles -> grant=8'h01 one cycle later, grant_idx=0, busy_cnt reaches 45, grant=0 one cycle after req drops, no timeout_err.
- Round robin: req=8'h0F held continuously, each owner drops its bit for 1 cycle after 46 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Wrap: rr_ptr=7 (port 6 served last), req=8'h81 -> grant goes to port 7 first, then port 0.
- Timeout: req=8'h04 held for 100 cycles -> grant drops after MAX_HOLD=64 cycles, timeout_err pulses once. Port 2 is not regranted while req[2] stays high; req[5] raised during DRAIN is granted only after req[2] falls.
- Reset mid-grant: grant=8'h10 active, reset_n pulled low between clock edges -> grant=0 and busy_cnt=0 immediately. After reset is released, req=8'h30 is granted to port 4 (rr_ptr=0).
- Simultaneous release and request: owner 1 drops req the same cycle port 3 raises req -> one idle cycle, then grant=8'h08.
